iopad_seq: RTL and testbench
============================

IOPAD_SEQ -- requirements
Module: iopad_seq

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the word length in bits; legal range 1..32.
REQ-002 Parameter TURN, default 2, SHALL set the bus-turnaround length in clock cycles; legal range 1..15.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 tx_valid  input  1  SHALL request transmission of tx_data.
REQ-006 tx_data  input  WIDTH  SHALL carry the word to transmit.
REQ-007 tx_ready  output  1  SHALL indicate a tx word can be accepted.
REQ-008 rx_req  input  1  SHALL request reception of one word from the pad.
REQ-009 rx_valid  output  1  SHALL pulse when rx_data holds a newly received word.
REQ-010 rx_data  output  WIDTH  SHALL carry the last received word.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 direction  output  1  SHALL drive the pad cell direction: 1 = pad-to-din (pad released), 0 = dout-to-pad (pad driven).
REQ-013 zin  output  1  SHALL drive the pad cell Z request; equal to direction at all times.
REQ-014 dout  output  1  SHALL carry the serial bit driven to the pad.
REQ-015 din  input  1  SHALL carry the serial bit sampled from the pad.

Function
REQ-016 FSM states SHALL be IDLE, TX_TURN, TX_SHIFT, TX_REL, RX_SHIFT; all outputs registered except tx_ready and busy, which decode the state.
REQ-017 tx_ready SHALL be 1 only in IDLE; a tx transfer occurs on a rising edge with tx_valid=1 and tx_ready=1.
REQ-018 On a tx transfer, tx_data SHALL be captured into a shift register and the state SHALL go to TX_TURN.
REQ-019 TX_TURN SHALL last exactly TURN cycles with direction=1, dout=0.
REQ-020 TX_SHIFT SHALL last exactly WIDTH cycles with direction=0, dout presenting tx_data MSB first, one bit per cycle.
REQ-021 TX_REL SHALL last exactly TURN cycles with direction=1, dout=0, then return to IDLE.
REQ-022 direction SHALL never be 0 outside TX_SHIFT, and SHALL never change from 1 to 0 without at least TURN preceding cycles at 1.
REQ-023 In IDLE with rx_req=1 and tx_valid=0, the state SHALL go to RX_SHIFT on the next edge.
REQ-024 In IDLE with tx_valid=1 and rx_req=1 simultaneously, tx SHALL win; rx_req is ignored (not queued).
REQ-025 RX_SHIFT SHALL last exactly WIDTH cycles with direction=1, sampling din on each rising edge in the state, MSB first.
REQ-026 On the edge leaving RX_SHIFT, rx_data SHALL load the assembled word and rx_valid SHALL be 1 for exactly one cycle.
REQ-027 rx_data SHALL hold its value until the next completed receive; rx_valid SHALL be 0 at all other times.
REQ-028 tx_valid, tx_data, rx_req SHALL be ignored outside IDLE; changes mid-operation have no effect.
REQ-029 Counters SHALL be sized to hold max(WIDTH, TURN) and SHALL not wrap inside a state.
REQ-030 Back-to-back transfers SHALL be accepted on the first IDLE cycle after return; minimum tx period = 2*TURN+WIDTH+1 cycles.

Reset
REQ-031 While rst_n=0, state SHALL be IDLE, direction=1, zin=1, dout=0, rx_valid=0, rx_data=0, shift register and counters 0.
REQ-032 Reset asserted mid-TX_SHIFT SHALL immediately (asynchronously) release the pad (direction=1) and abort the transfer with no rx_valid.
REQ-033 No transfer SHALL be accepted on the edge on which rst_n is sampled low; the first acceptance is on the first edge with rst_n=1.

Verification
REQ-034 WIDTH=8, TURN=2: tx_data=0xA5 accepted -> direction=1 for 2 cycles, 0 for 8 cycles with dout=1,0,1,0,0,1,0,1, then 1 for 2 cycles; tx_ready high again at cycle 13.
REQ-035 rx_req=1, din driven 0x3C MSB first over 8 cycles -> rx_data=0x3C, rx_valid high exactly one cycle, direction=1 throughout.
REQ-036 tx_valid=1 and rx_req=1 in same IDLE cycle with tx_data=0xFF -> tx sequence runs, no RX_SHIFT, rx_valid stays 0.
REQ-037 rst_n pulled low at 4th TX_SHIFT cycle -> direction=1, dout=0 immediately; after release, IDLE with tx_ready=1.
REQ-038 tx_valid held high for two words 0x01, 0x80 -> second accepted on first IDLE cycle; direction never 0 during any TX_REL or TX_TURN cycle.
REQ-039 WIDTH=1, TURN=1: tx_data=1 -> sequence 1 cycle released, 1 cycle driven with dout=1, 1 cycle released; zin equals direction on every cycle.

Source files
------------

// File: rtl/iopad_seq.sv
// Bidirectional single-pin serial sequencer: shifts words out to / in from a pad,
// inserting bus-turnaround gaps so the pad is never driven without a release window.
module iopad_seq #(
   parameter int WIDTH = 8,
   parameter int TURN  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tx_valid,
   input  logic [WIDTH-1:0] tx_data,
   output logic             tx_ready,
   input  logic             rx_req,
   output logic             rx_valid,
   output logic [WIDTH-1:0] rx_data,
   output logic             busy,
   output logic             direction,
   output logic             zin,
   output logic             dout,
   input  logic             din,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      TX_TURN  = 3'd1,
      TX_SHIFT = 3'd2,
      TX_REL   = 3'd3,
      RX_SHIFT = 3'd4
   } state_t;

   localparam int MAXV = (WIDTH > TURN) ? WIDTH : TURN;
   localparam int CW   = $clog2(MAXV + 1);
   localparam logic [CW-1:0] TURN_LAST  = CW'(TURN - 1);
   localparam logic [CW-1:0] WIDTH_LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] rx_next;

   // Handshake: a tx word moves on a rising edge where tx_valid && tx_ready;
   // tx_ready is high only in IDLE, and tx_valid may be held across the whole operation.
   assign tx_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign zin       = direction;
   assign state_dbg = state;
   assign rx_next   = (sr << 1) | WIDTH'(din);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         sr        <= '0;
         direction <= 1'b1;
         dout      <= 1'b0;
         rx_valid  <= 1'b0;
         rx_data   <= '0;
      end else begin
         rx_valid <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (tx_valid) begin
                  sr    <= tx_data;
                  state <= TX_TURN;
               end else if (rx_req) begin
                  sr    <= '0;
                  state <= RX_SHIFT;
               end
            end
            TX_TURN: begin
               // Driving starts only after the full release window has elapsed.
               if (cnt == TURN_LAST) begin
                  cnt       <= '0;
                  state     <= TX_SHIFT;
                  direction <= 1'b0;
                  dout      <= sr[WIDTH-1];
                  sr        <= sr << 1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            TX_SHIFT: begin
               if (cnt == WIDTH_LAST) begin
                  cnt       <= '0;
                  state     <= TX_REL;
                  direction <= 1'b1;
                  dout      <= 1'b0;
               end else begin
                  cnt  <= cnt + 1'b1;
                  dout <= sr[WIDTH-1];
                  sr   <= sr << 1;
               end
            end
            TX_REL: begin
               if (cnt == TURN_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_SHIFT: begin
               sr <= rx_next;
               if (cnt == WIDTH_LAST) begin
                  cnt      <= '0;
                  state    <= IDLE;
                  rx_data  <= rx_next;
                  rx_valid <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               direction <= 1'b1;
               dout      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iopad_seq.sv
// Directed bench for iopad_seq: an 8-bit/turn-2 instance and a 1-bit/turn-1 instance
// sharing clock and reset, checked against hand-computed pad sequences.
module tb_iopad_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // WIDTH=8, TURN=2 instance
   logic       tx_valid, tx_ready, rx_req, rx_valid, busy, direction, zin, dout, din;
   logic [7:0] tx_data, rx_data;
   logic [2:0] state_dbg;

   // WIDTH=1, TURN=1 instance
   logic       t1_valid, t1_ready, t1_rx_req, t1_rx_valid, t1_busy, t1_dir, t1_zin, t1_dout, t1_din;
   logic [0:0] t1_data, t1_rx_data;
   logic [2:0] t1_state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   iopad_seq #(.WIDTH(8), .TURN(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_req(rx_req), .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
      .direction(direction), .zin(zin), .dout(dout), .din(din), .state_dbg(state_dbg)
   );

   iopad_seq #(.WIDTH(1), .TURN(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(t1_valid), .tx_data(t1_data), .tx_ready(t1_ready),
      .rx_req(t1_rx_req), .rx_valid(t1_rx_valid), .rx_data(t1_rx_data), .busy(t1_busy),
      .direction(t1_dir), .zin(t1_zin), .dout(t1_dout), .din(t1_din), .state_dbg(t1_state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expects the accepting edge to be the next one; after it, drives tx_valid/tx_data
   // to the given values (mid-operation changes must be ignored).
   task automatic tx_run(input logic [7:0] word, input logic hold, input logic [7:0] next_data);
      logic exp_dir, exp_dout;
      for (int i = 1; i <= 13; i++) begin
         tick();
         if (i == 1) begin
            tx_valid = hold;
            tx_data  = next_data;
            rx_req   = 1'b0;
         end
         exp_dir  = (i >= 3 && i <= 10) ? 1'b0 : 1'b1;
         exp_dout = exp_dir ? 1'b0 : word[10-i];
         check("tx_dir", direction, exp_dir);
         check("tx_zin", zin, exp_dir);
         check("tx_dout", dout, exp_dout);
         check("tx_rxv", rx_valid, 1'b0);
         check("tx_ready", tx_ready, (i == 13));
      end
   endtask

   initial begin
      logic [7:0] rx_pat;
      rst_n = 1'b0;
      tx_valid = 1'b0; tx_data = 8'h00; rx_req = 1'b0; din = 1'b0;
      t1_valid = 1'b0; t1_data = 1'b0; t1_rx_req = 1'b0; t1_din = 1'b0;
      repeat (2) tick();

      // reset values
      check("rst_dir", direction, 1'b1);
      check("rst_zin", zin, 1'b1);
      check("rst_dout", dout, 1'b0);
      check("rst_rxv", rx_valid, 1'b0);
      check("rst_rxdata", rx_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", tx_ready, 1'b1);
      rst_n = 1'b1;
      tick();

      // single tx of 0xA5, with tx_data changed mid-operation
      tx_valid = 1'b1; tx_data = 8'hA5;
      tx_run(8'hA5, 1'b0, 8'h5A);

      // receive 0x3C
      rx_pat = 8'h3C;
      rx_req = 1'b1;
      tick();
      rx_req = 1'b0;
      for (int b = 7; b >= 0; b--) begin
         din = rx_pat[b];
         check("rx_dir", direction, 1'b1);
         check("rx_busy", busy, 1'b1);
         check("rx_valid_low", rx_valid, 1'b0);
         tick();
      end
      check("rx_valid", rx_valid, 1'b1);
      check("rx_data", rx_data, 8'h3C);
      check("rx_idle", busy, 1'b0);
      din = 1'b1;
      tick();
      check("rx_valid_pulse", rx_valid, 1'b0);
      check("rx_data_hold", rx_data, 8'h3C);

      // tx and rx requested together: tx wins, rx not queued
      tx_valid = 1'b1; tx_data = 8'hFF; rx_req = 1'b1;
      tx_run(8'hFF, 1'b0, 8'h00);
      tick();
      check("coll_busy", busy, 1'b0);
      check("coll_rxv", rx_valid, 1'b0);
      check("coll_rxdata", rx_data, 8'h3C);

      // back-to-back words 0x01 then 0x80 with tx_valid held
      tx_valid = 1'b1; tx_data = 8'h01;
      tx_run(8'h01, 1'b1, 8'h80);
      tx_run(8'h80, 1'b0, 8'h00);

      // reset in the 4th driven cycle
      tx_valid = 1'b1; tx_data = 8'hA5;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 1) tx_valid = 1'b0;
      end
      check("pre_rst_dir", direction, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("async_dir", direction, 1'b1);
      check("async_zin", zin, 1'b1);
      check("async_dout", dout, 1'b0);
      check("async_busy", busy, 1'b0);
      check("async_rxv", rx_valid, 1'b0);
      check("async_rxdata", rx_data, 8'h00);
      tx_valid = 1'b1; tx_data = 8'hC3;
      tick();
      check("rst_no_accept", busy, 1'b0);
      check("rst_ready_idle", tx_ready, 1'b1);
      rst_n = 1'b1;
      tick();
      check("post_rst_accept", busy, 1'b1);
      tx_valid = 1'b0;
      repeat (12) tick();
      check("post_rst_done", tx_ready, 1'b1);

      // WIDTH=1, TURN=1 instance
      t1_valid = 1'b1; t1_data = 1'b1;
      tick();
      t1_valid = 1'b0;
      check("w1_turn_dir", t1_dir, 1'b1);
      check("w1_turn_zin", t1_zin, 1'b1);
      check("w1_turn_dout", t1_dout, 1'b0);
      tick();
      check("w1_shift_dir", t1_dir, 1'b0);
      check("w1_shift_zin", t1_zin, 1'b0);
      check("w1_shift_dout", t1_dout, 1'b1);
      tick();
      check("w1_rel_dir", t1_dir, 1'b1);
      check("w1_rel_zin", t1_zin, 1'b1);
      check("w1_rel_dout", t1_dout, 1'b0);
      check("w1_rel_busy", t1_busy, 1'b1);
      tick();
      check("w1_idle_ready", t1_ready, 1'b1);
      check("w1_idle_zin", t1_zin, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
